// File: rtl/freq_peak_detect.sv
// Finds the peak-magnitude bin of each 16-bin FFT frame; result 17 cycles after fft_valid from idle.
// No backpressure: a one-frame pending bank absorbs cadence, newer frames overwrite it (sticky overflow).
module freq_peak_detect #(
  parameter int FRAMES  = 64,
  parameter bit SKIP_DC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic [3:0]  freq,
  output logic        freq_valid,
  output logic        busy,
  output logic        overflow,
  output logic        done
);

  localparam int CW = $clog2(FRAMES + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [31:0]   fft_in [16];
  logic [31:0]   pend_bank_q [16];
  logic [31:0]   pend_bank_d [16];
  logic [31:0]   work_bank_q [16];
  logic [31:0]   work_bank_d [16];
  logic          pend_q, pend_d;
  logic [0:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [31:0]   best_mag_q, best_mag_d;
  logic [3:0]    best_idx_q, best_idx_d;
  logic [3:0]    freq_q, freq_d;
  logic          freq_vld_q, freq_vld_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic               consume;
  logic signed [15:0] re_s, im_s;
  logic signed [31:0] re_sq, im_sq;
  logic [31:0]        mag;
  logic               gt;

  always_comb begin
    fft_in[0]  = fft_d0;  fft_in[1]  = fft_d1;  fft_in[2]  = fft_d2;  fft_in[3]  = fft_d3;
    fft_in[4]  = fft_d4;  fft_in[5]  = fft_d5;  fft_in[6]  = fft_d6;  fft_in[7]  = fft_d7;
    fft_in[8]  = fft_d8;  fft_in[9]  = fft_d9;  fft_in[10] = fft_d10; fft_in[11] = fft_d11;
    fft_in[12] = fft_d12; fft_in[13] = fft_d13; fft_in[14] = fft_d14; fft_in[15] = fft_d15;
  end

  // Each square is at most 2^30, so the unsigned sum cannot wrap.
  always_comb begin
    re_s  = work_bank_q[idx_q][31:16];
    im_s  = work_bank_q[idx_q][15:0];
    re_sq = re_s * re_s;
    im_sq = im_s * im_s;
    mag   = $unsigned(re_sq) + $unsigned(im_sq);
    if (SKIP_DC && (idx_q == 4'd0)) begin
      mag = '0;
    end
    gt = (mag > best_mag_q);
  end

  always_comb begin
    pend_bank_d = pend_bank_q;
    work_bank_d = work_bank_q;
    pend_d      = pend_q;
    state_d     = state_q;
    idx_d       = idx_q;
    best_mag_d  = best_mag_q;
    best_idx_d  = best_idx_q;
    freq_d      = freq_q;
    freq_vld_d  = 1'b0;
    overflow_d  = overflow_q;
    done_d      = done_q;
    cnt_d       = cnt_q;

    consume = pend_q && ((state_q == IDLE) || (idx_q == 4'd15));

    // A consume at the same edge frees the slot, so only an unconsumed overwrite is an overflow.
    if (fft_valid) begin
      pend_bank_d = fft_in;
      pend_d      = 1'b1;
      if (pend_q && !consume) begin
        overflow_d = 1'b1;
      end
    end else if (consume) begin
      pend_d = 1'b0;
    end

    if (state_q == IDLE) begin
      if (pend_q) begin
        work_bank_d = pend_bank_q;
        idx_d       = '0;
        best_mag_d  = '0;
        best_idx_d  = '0;
        state_d     = CALC;
      end
    end else begin
      if (gt) begin
        best_mag_d = mag;
        best_idx_d = idx_q;
      end
      idx_d = idx_q + 4'd1;
      if (idx_q == 4'd15) begin
        freq_d     = gt ? idx_q : best_idx_q;
        freq_vld_d = 1'b1;
        cnt_d      = (cnt_q == CW'(FRAMES)) ? cnt_q : cnt_q + 1'b1;
        done_d     = done_q || (cnt_d == CW'(FRAMES));
        if (pend_q) begin
          work_bank_d = pend_bank_q;
          idx_d       = '0;
          best_mag_d  = '0;
          best_idx_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end

    busy_d = (state_d == CALC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 16; k++) begin
        pend_bank_q[k] <= '0;
        work_bank_q[k] <= '0;
      end
      pend_q     <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= '0;
      best_mag_q <= '0;
      best_idx_q <= '0;
      freq_q     <= '0;
      freq_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pend_bank_q <= pend_bank_d;
      work_bank_q <= work_bank_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_mag_q  <= best_mag_d;
      best_idx_q  <= best_idx_d;
      freq_q      <= freq_d;
      freq_vld_q  <= freq_vld_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_vld_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign done       = done_q;

endmodule

// File: tb/tb_freq_peak_detect.sv
// Bench for freq_peak_detect: two instances (SKIP_DC=1 and 0) fed identically, scoreboard of expected results.
module tb_freq_peak_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] fft_d [16];
  logic [3:0]  freq1, freq0;
  logic        fv1, fv0, busy1, busy0, ovf1, ovf0, done1, done0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_seen = 0;
  bit ovf_set = 0;
  int ovf_edge = 0;

  typedef struct {
    logic [3:0] f1;
    logic [3:0] f0;
    int         res;
    int         load;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] cur_fr [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  freq_peak_detect #(.FRAMES(64), .SKIP_DC(1'b1)) dut1 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fft_d[0]), .fft_d1(fft_d[1]), .fft_d2(fft_d[2]), .fft_d3(fft_d[3]),
    .fft_d4(fft_d[4]), .fft_d5(fft_d[5]), .fft_d6(fft_d[6]), .fft_d7(fft_d[7]),
    .fft_d8(fft_d[8]), .fft_d9(fft_d[9]), .fft_d10(fft_d[10]), .fft_d11(fft_d[11]),
    .fft_d12(fft_d[12]), .fft_d13(fft_d[13]), .fft_d14(fft_d[14]), .fft_d15(fft_d[15]),
    .freq(freq1), .freq_valid(fv1), .busy(busy1), .overflow(ovf1), .done(done1)
  );

  freq_peak_detect #(.FRAMES(64), .SKIP_DC(1'b0)) dut0 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fft_d[0]), .fft_d1(fft_d[1]), .fft_d2(fft_d[2]), .fft_d3(fft_d[3]),
    .fft_d4(fft_d[4]), .fft_d5(fft_d[5]), .fft_d6(fft_d[6]), .fft_d7(fft_d[7]),
    .fft_d8(fft_d[8]), .fft_d9(fft_d[9]), .fft_d10(fft_d[10]), .fft_d11(fft_d[11]),
    .fft_d12(fft_d[12]), .fft_d13(fft_d[13]), .fft_d14(fft_d[14]), .fft_d15(fft_d[15]),
    .freq(freq0), .freq_valid(fv0), .busy(busy0), .overflow(ovf0), .done(done0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] peak(input bit skip);
    longint best = 0;
    longint mag;
    int     re, im;
    logic [3:0] bi = 4'd0;
    for (int k = 0; k < 16; k++) begin
      re  = $signed(cur_fr[k][31:16]);
      im  = $signed(cur_fr[k][15:0]);
      mag = (skip && k == 0) ? 0 : longint'(re) * re + longint'(im) * im;
      if (mag > best) begin
        best = mag;
        bi   = 4'(k);
      end
    end
    return bi;
  endfunction

  // Frame sampled at edge n: a still-unloaded pending frame is replaced, otherwise queued behind the last.
  function automatic void push_model(input int n);
    exp_t e;
    if (exp_q.size() > 0 && n < exp_q[$].load) begin
      void'(exp_q.pop_back());
      if (!ovf_set) ovf_edge = n;
      ovf_set = 1;
    end
    e.f1   = peak(1'b1);
    e.f0   = peak(1'b0);
    e.res  = n + 17;
    if (exp_q.size() > 0 && exp_q[$].res + 16 > e.res) e.res = exp_q[$].res + 16;
    e.load = e.res - 16;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (fv1 || fv0) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(fv1 | fv0), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        frames_seen++;
        check_eq("valid_skip", 32'(fv1), 1);
        check_eq("valid_noskip", 32'(fv0), 1);
        check_eq("result_cycle", cyc, e.res);
        check_eq("freq_skip", 32'(freq1), 32'(e.f1));
        check_eq("freq_noskip", 32'(freq0), 32'(e.f0));
        check_eq("done", 32'(done1), 32'(frames_seen >= 64));
        check_eq("overflow", 32'(ovf1), 32'(ovf_set && cyc >= ovf_edge));
        check_eq("busy", 32'(busy1), 32'(exp_q.size() > 0 && exp_q[0].load == cyc));
      end
    end
  end

  task automatic send(input int sp);
    @(posedge clk);
    #2;
    fft_d     = cur_fr;
    fft_valid = 1'b1;
    push_model(cyc + 1);
    @(posedge clk);
    #2;
    fft_valid = 1'b0;
    repeat (sp - 2) @(posedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check_eq("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic clear_fr();
    for (int k = 0; k < 16; k++) cur_fr[k] = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_freq"}, 32'(freq1), 0);
    check_eq({tag, "_valid"}, 32'(fv1), 0);
    check_eq({tag, "_busy"}, 32'(busy1), 0);
    check_eq({tag, "_overflow"}, 32'(ovf1), 0);
    check_eq({tag, "_done"}, 32'(done1), 0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) fft_d[k] = 32'h0;
    clear_fr();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #1 rst = 1'b1;

    // Single peak: bin 5 (65536) beats bin 9 (65025).
    clear_fr();
    cur_fr[5] = 32'h0100_0000;
    cur_fr[9] = 32'h0000_00FF;
    send(20);
    drain();

    // Most-negative extreme, tie resolution, all-zero, DC handling.
    clear_fr(); cur_fr[3] = 32'h8000_8000; send(20);
    clear_fr(); cur_fr[2] = 32'h0040_0040; cur_fr[7] = 32'h0040_0040; send(20);
    clear_fr(); send(20);
    clear_fr(); cur_fr[0] = 32'h7FFF_0000; cur_fr[1] = 32'h0001_0000; send(20);
    drain();

    // Overrun: the middle frame is lost.
    clear_fr(); cur_fr[4]  = 32'h0100_0000; send(4);
    clear_fr(); cur_fr[6]  = 32'h0100_0000; send(4);
    clear_fr(); cur_fr[11] = 32'h0100_0000; send(4);
    drain();
    check_eq("overflow_sticky", 32'(ovf1), 1);

    // Reset in the middle of CALC with a frame pending.
    clear_fr(); cur_fr[2] = 32'h0100_0000; send(4);
    clear_fr(); cur_fr[3] = 32'h0100_0000; send(4);
    check_eq("busy_before_reset", 32'(busy1), 1);
    #2 rst = 1'b0;
    exp_q.delete();
    frames_seen = 0;
    ovf_set = 0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (25) @(posedge clk);
    check_eq("no_partial_result", 32'(frames_seen), 0);
    clear_fr(); cur_fr[7] = 32'h0100_0000; send(20);
    drain();

    // Cadence: 70 frames, 16 cycles apart, peak index cycling 1..15.
    for (int i = 0; i < 70; i++) begin
      for (int k = 0; k < 16; k++) begin
        cur_fr[k] = {16'($signed($urandom_range(32) - 16)), 16'($signed($urandom_range(32) - 16))};
      end
      cur_fr[(i % 15) + 1] = 32'h0100_0100;
      send(16);
    end
    drain();
    check_eq("frames_reported", 32'(frames_seen), 71);
    check_eq("done_final", 32'(done1), 1);
    check_eq("done_final_noskip", 32'(done0), 1);
    check_eq("overflow_after_cadence", 32'(ovf1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
